fix_div_arbiter: RTL and testbench

Round-robin scheduler that shares one combinational fixed-point divider (signed Q(WIDTH-FRAC_WIDTH).FRAC_WIDTH) among NUM_REQ physics requesters, such as the per-ball collision and normalisation units. It accepts one request at a time over a valid/ready handshake and drives the divider operands from registers. It waits a fixed multicycle settle window, then returns the registered quotient to the granted requester. Divide-by-zero is detected and optionally saturated without using the divider.

---
 rtl/fix_div_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fix_div_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_div_arbiter.sv
// Round-robin scheduler sharing one multicycle fixed-point divider among NUM_REQ requesters.
// Optional macro FIX_DIV_ZERO_SAT_EN: saturate divide-by-zero without waiting on the divider.
module fix_div_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FRAC_WIDTH = 30,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DIV_LAT    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_x_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_y_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  input  logic [NUM_REQ-1:0]       rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_q_o,
  output logic                     rsp_dz_o,
  output logic [WIDTH-1:0]         div_x_o,
  output logic [WIDTH-1:0]         div_y_o,
  input  logic [WIDTH-1:0]         div_q_i
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(DIV_LAT + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  if (FRAC_WIDTH >= WIDTH || NUM_REQ < 2 || NUM_REQ > 16 || DIV_LAT < 1) begin : g_param_check
    $error("fix_div_arbiter: illegal parameter combination");
  end

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] div_x_q, div_x_d;
  logic [WIDTH-1:0] div_y_q, div_y_d;
  logic [WIDTH-1:0] rsp_q_q, rsp_q_d;

  logic [IW-1:0]    grant_idx;
  logic             grant_found;
  logic [IW-1:0]    probe_idx;
  logic [WIDTH-1:0] sel_x, sel_y;

  // Scan from farthest to nearest so the nearest valid requester after last_q wins.
  always_comb begin
    grant_idx   = last_q;
    grant_found = 1'b0;
    probe_idx   = '0;
    for (int unsigned off = NUM_REQ; off >= 1; off--) begin
      probe_idx = IW'((32'(last_q) + off) % NUM_REQ);
      if (req_valid_i[probe_idx]) begin
        grant_idx   = probe_idx;
        grant_found = 1'b1;
      end
    end
  end

  assign sel_x = req_x_i[grant_idx*WIDTH +: WIDTH];
  assign sel_y = req_y_i[grant_idx*WIDTH +: WIDTH];

  always_comb begin
    req_ready_o = '0;
    if (state_q == StIdle && grant_found && !rst_i) begin
      req_ready_o[grant_idx] = 1'b1;
    end
    rsp_valid_o = '0;
    if (state_q == StResp) begin
      rsp_valid_o[grant_q] = 1'b1;
    end
  end

`ifdef FIX_DIV_ZERO_SAT_EN
  logic rsp_dz_q, rsp_dz_d;
  assign rsp_dz_o = rsp_dz_q;
`else
  assign rsp_dz_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    div_x_d = div_x_q;
    div_y_d = div_y_q;
    rsp_q_d = rsp_q_q;
`ifdef FIX_DIV_ZERO_SAT_EN
    rsp_dz_d = rsp_dz_q;
`endif
    case (state_q)
      StIdle: begin
        if (grant_found) begin
          div_x_d = sel_x;
          div_y_d = sel_y;
          last_d  = grant_idx;
          grant_d = grant_idx;
          state_d = StWait;
          cnt_d   = CW'(DIV_LAT - 1);
`ifdef FIX_DIV_ZERO_SAT_EN
          if (sel_y == '0) begin
            state_d  = StResp;
            cnt_d    = cnt_q;
            rsp_dz_d = 1'b1;
            rsp_q_d  = sel_x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          rsp_q_d = div_q_i;
`ifdef FIX_DIV_ZERO_SAT_EN
          rsp_dz_d = 1'b0;
`endif
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i[grant_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      last_q  <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      div_x_q <= '0;
      div_y_q <= '0;
      rsp_q_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      div_x_q <= div_x_d;
      div_y_q <= div_y_d;
      rsp_q_q <= rsp_q_d;
    end
  end

`ifdef FIX_DIV_ZERO_SAT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_dz_q <= 1'b0;
    end else begin
      rsp_dz_q <= rsp_dz_d;
    end
  end
`endif

  assign div_x_o = div_x_q;
  assign div_y_o = div_y_q;
  assign rsp_q_o = rsp_q_q;

endmodule

// File: tb/tb_fix_div_arbiter.sv
// Self-checking bench for fix_div_arbiter: behavioural divider plus round-robin reference model.
module tb_fix_div_arbiter;

  localparam int W  = 32;
  localparam int FR = 30;
  localparam int NR = 4;
  localparam int DL = 2;

  logic              clk, rst;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*W-1:0]   req_x, req_y;
  logic [W-1:0]      rsp_q, div_x, div_y, div_q;
  logic              rsp_dz;

  int errors = 0;
  int checks = 0;
  int model_last = NR - 1;

  fix_div_arbiter #(
    .WIDTH     (W),
    .FRAC_WIDTH(FR),
    .NUM_REQ   (NR),
    .DIV_LAT   (DL)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_x_i    (req_x),
    .req_y_i    (req_y),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_q_o    (rsp_q),
    .rsp_dz_o   (rsp_dz),
    .div_x_o    (div_x),
    .div_y_o    (div_y),
    .div_q_i    (div_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed Q2.30 divider; divide-by-zero yields an arbitrary marker value.
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y);
    longint a, q;
    if (y == '0) return 32'hDEAD_BEEF;
    a = longint'($signed(x)) <<< FR;
    q = a / longint'($signed(y));
    return q[W-1:0];
  endfunction

  assign div_q = ref_div(div_x, div_y);

  function automatic logic [W-1:0] exp_rsp(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef FIX_DIV_ZERO_SAT_EN
    if (y == '0) return x[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return ref_div(x, y);
  endfunction

  function automatic logic exp_dz(input logic [W-1:0] y);
`ifdef FIX_DIV_ZERO_SAT_EN
    return (y == '0);
`else
    return 1'b0 & (y == '0);
`endif
  endfunction

  function automatic int exp_lat(input logic [W-1:0] y);
`ifdef FIX_DIV_ZERO_SAT_EN
    if (y == '0) return 1;
`endif
    return DL + 1;
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] m, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (m[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Present a request mask until accepted, then wait for the response; lat=-1 on timeout.
  task automatic run_txn(input logic [NR-1:0] mask, input logic [NR*W-1:0] xs,
                         input logic [NR*W-1:0] ys, input logic [NR-1:0] rmask,
                         output logic [NR-1:0] rdy, output int lat, output logic [W-1:0] q,
                         output logic dz, output logic [NR-1:0] rv);
    int n;
    req_x = xs; req_y = ys; rsp_ready = rmask; req_valid = mask;
    #1;
    n = 0;
    while (req_ready == '0 && n < 50) begin
      @(posedge clk); #2; n++;
    end
    rdy = req_ready;
    lat = -1; q = '0; dz = 1'b0; rv = '0;
    if (rdy == '0) begin
      req_valid = '0;
      return;
    end
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    n = 1;
    while (rsp_valid == '0 && n < 50) begin
      @(posedge clk); #2; n++;
    end
    if (rsp_valid != '0) lat = n;
    q = rsp_q; dz = rsp_dz; rv = rsp_valid;
  endtask

  task automatic finish_rsp(input int g);
    rsp_ready = '0;
    if (g >= 0) rsp_ready[g] = 1'b1;
    @(posedge clk); #1;
    rsp_ready = '0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; rsp_ready = '0; req_x = '1; req_y = '1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0) begin
      errors++; $display("FAIL reset_hs: ready=%b valid=%b expected 0000 0000", req_ready, rsp_valid);
    end
    checks++;
    if (rsp_q !== '0 || rsp_dz !== 1'b0 || div_x !== '0 || div_y !== '0) begin
      errors++; $display("FAIL reset_data: q=%h dz=%b dx=%h dy=%h expected zeros",
                         rsp_q, rsp_dz, div_x, div_y);
    end
    rst = 1'b0; req_valid = '0;
    model_last = NR - 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [NR*W-1:0] xs, ys;
    logic [NR-1:0] rdy, rv;
    logic [W-1:0] q;
    logic dz;
    int lat;
    xs = '0; ys = '0;
    xs[0 +: W] = 32'h2000_0000; ys[0 +: W] = 32'h4000_0000;
    run_txn(4'b0001, xs, ys, 4'b0000, rdy, lat, q, dz, rv);
    checks++;
    if (rdy !== 4'b0001) begin
      errors++; $display("FAIL single_ready: got %b expected 0001", rdy);
    end
    checks++;
    if (lat != DL + 1) begin
      errors++; $display("FAIL single_latency: got %0d expected %0d", lat, DL + 1);
    end
    checks++;
    if (q !== 32'h2000_0000 || dz !== 1'b0 || rv !== 4'b0001) begin
      errors++; $display("FAIL single_rsp: q=%h dz=%b rv=%b expected 20000000 0 0001", q, dz, rv);
    end
    checks++;
    if (div_x !== 32'h2000_0000 || div_y !== 32'h4000_0000) begin
      errors++; $display("FAIL single_operands: dx=%h dy=%h expected 20000000 40000000",
                         div_x, div_y);
    end
    model_last = 0;
    finish_rsp(0);
    req_valid = '1;
    #1;
    checks++;
    if (rsp_valid !== '0 || req_ready !== (4'b0001 << rr_pick(4'b1111, model_last))) begin
      errors++; $display("FAIL single_idle: rv=%b rdy=%b expected 0000 %b", rsp_valid, req_ready,
                         4'b0001 << rr_pick(4'b1111, model_last));
    end
    #1;
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    logic [NR*W-1:0] xs, ys;
    logic [NR-1:0] rdy, rv;
    logic [W-1:0] q;
    logic dz;
    int lat;
    xs = '0; ys = '0;
    xs[2*W +: W] = 32'hE000_0000; ys[2*W +: W] = 32'h2000_0000;
    run_txn(4'b0100, xs, ys, 4'b0000, rdy, lat, q, dz, rv);
    checks++;
    if (q !== 32'hC000_0000 || dz !== 1'b0 || rv !== 4'b0100 || lat != DL + 1) begin
      errors++; $display("FAIL signed_rsp: q=%h dz=%b rv=%b lat=%0d expected c0000000 0 0100 %0d",
                         q, dz, rv, lat, DL + 1);
    end
    model_last = 2;
    finish_rsp(2);
  endtask

  task automatic test_div_zero();
    logic [NR*W-1:0] xs, ys;
    logic [NR-1:0] rdy, rv;
    logic [W-1:0] q, xv;
    logic dz;
    int lat;
    for (int i = 0; i < 2; i++) begin
      xv = (i == 0) ? 32'h1000_0000 : 32'h8000_0000;
      xs = '0; ys = '0;
      xs[W +: W] = xv;
      run_txn(4'b0010, xs, ys, 4'b0000, rdy, lat, q, dz, rv);
      checks++;
      if (lat != exp_lat('0)) begin
        errors++; $display("FAIL dz_latency_%0d: got %0d expected %0d", i, lat, exp_lat('0));
      end
      checks++;
      if (q !== exp_rsp(xv, '0) || dz !== exp_dz('0) || rv !== 4'b0010) begin
        errors++; $display("FAIL dz_rsp_%0d: q=%h dz=%b rv=%b expected %h %b 0010", i, q, dz, rv,
                           exp_rsp(xv, '0), exp_dz('0));
      end
      checks++;
      if (div_x !== xv || div_y !== '0) begin
        errors++; $display("FAIL dz_operands_%0d: dx=%h dy=%h expected %h 0", i, div_x, div_y, xv);
      end
      model_last = 1;
      finish_rsp(1);
    end
  endtask

  task automatic test_backpressure();
    logic [NR*W-1:0] xs, ys;
    logic [NR-1:0] rdy, rv;
    logic [W-1:0] q;
    logic dz;
    int lat;
    int bad;
    xs = '0; ys = '0;
    xs[W +: W] = 32'h3000_0000; ys[W +: W] = 32'h4000_0000;
    xs[3*W +: W] = 32'h1000_0000; ys[3*W +: W] = 32'h4000_0000;
    run_txn(4'b0010, xs, ys, 4'b1101, rdy, lat, q, dz, rv);
    checks++;
    if (q !== 32'h3000_0000 || rv !== 4'b0010) begin
      errors++; $display("FAIL bp_rsp: q=%h rv=%b expected 30000000 0010", q, rv);
    end
    req_valid = 4'b1000;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #2;
      if (rsp_valid !== 4'b0010 || rsp_q !== 32'h3000_0000 || req_ready !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_stall: got %0d unstable cycles expected 0", bad);
    end
    model_last = 1;
    finish_rsp(1);
    checks++;
    if (req_ready !== (4'b0001 << rr_pick(4'b1000, model_last))) begin
      errors++; $display("FAIL bp_next_grant: got %b expected 1000", req_ready);
    end
    #1;
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [NR*W-1:0] xs, ys;
    logic [NR-1:0] rdy, rv, mask;
    logic [W-1:0] q, xg, yg;
    logic dz;
    int lat, g;
    for (int t = 0; t < 16; t++) begin
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      for (int k = 0; k < NR; k++) begin
        xs[k*W +: W] = $urandom;
        ys[k*W +: W] = $urandom;
        if (ys[k*W +: W] == '0) ys[k*W +: W] = 32'h0000_0001;
      end
      g = rr_pick(mask, model_last);
      xg = xs[g*W +: W];
      yg = ys[g*W +: W];
      run_txn(mask, xs, ys, 4'b0000, rdy, lat, q, dz, rv);
      checks++;
      if (rdy !== (4'b0001 << g)) begin
        errors++; $display("FAIL rand_grant_%0d: got %b expected %b", t, rdy, 4'b0001 << g);
      end
      checks++;
      if (lat != DL + 1 || q !== exp_rsp(xg, yg) || dz !== 1'b0 || rv !== (4'b0001 << g)) begin
        errors++; $display("FAIL rand_rsp_%0d: q=%h dz=%b rv=%b lat=%0d expected %h 0 %b %0d", t,
                           q, dz, rv, lat, exp_rsp(xg, yg), 4'b0001 << g, DL + 1);
      end
      model_last = g;
      finish_rsp(g);
    end
  endtask

  task automatic test_round_robin();
    int order[5];
    int when[5];
    int n;
    rst = 1'b1; req_valid = '1; rsp_ready = '1;
    for (int k = 0; k < NR; k++) begin
      req_x[k*W +: W] = 32'h0100_0000 * (k + 1);
      req_y[k*W +: W] = 32'h4000_0000;
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (req_ready != '0) begin
        order[n] = oh_idx(req_ready);
        when[n] = c;
        n++;
      end
      @(posedge clk); #2;
    end
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL rr_count: got %0d accepts expected 5", n);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] != i % NR || (i > 0 && when[i] - when[i-1] != DL + 2)) begin
          errors++; $display("FAIL rr_accept_%0d: grant=%0d gap=%0d expected %0d %0d", i,
                             order[i], (i > 0) ? when[i] - when[i-1] : DL + 2, i % NR, DL + 2);
        end
      end
    end
    req_valid = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
    end
    rsp_ready = '0;
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    req_x[2*W +: W] = 32'h1000_0000; req_y[2*W +: W] = 32'h4000_0000;
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL rmw_accept: got %b expected 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 4'b1000;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_q !== '0 || rsp_dz !== 1'b0 ||
        div_x !== '0 || div_y !== '0) begin
      errors++; $display("FAIL rmw_async: rdy=%b rv=%b q=%h dz=%b dx=%h dy=%h expected zeros",
                         req_ready, rsp_valid, rsp_q, rsp_dz, div_x, div_y);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #2;
      if (rsp_valid != '0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rmw_no_rsp: got %0d response cycles expected 0", seen);
    end
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rmw_first_grant: got %b expected 0001", req_ready);
    end
    #1;
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_x = '0; req_y = '0;
    test_reset();
    test_single();
    test_signed();
    test_div_zero();
    test_backpressure();
    test_random();
    test_round_robin();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
